bp_me_cce_mem_delay_model: RTL

// - Non-synthesizable memory stub directly downstream of the buffered CCE in the CCE unit bench.
// - Consumes CCE mem_cmd (valid/yumi) and returns a mem_resp (valid/ready) after a fixed delay.
// - Backed by a small block-addressed flop-array RAM.
// - Exactly one command is outstanding at a time.

---
 rtl/bp_me_cce_mem_delay_model_if.sv | 27 ++
 rtl/bp_me_cce_mem_delay_model.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/bp_me_cce_mem_delay_model_if.sv
// Handshake bundle between the CCE mem_cmd/mem_resp side and the memory stub.
//   width_p          : width of one packed message {data, payload, size, addr, msg_type}
//   mem_cmd_i        : command message (CCE -> mem)
//   mem_cmd_v_i      : command valid   (CCE -> mem)
//   mem_cmd_yumi_o   : command consumed this cycle (mem -> CCE)
//   mem_resp_o       : response message (mem -> CCE)
//   mem_resp_v_o     : response valid   (mem -> CCE)
//   mem_resp_ready_i : response accepted (CCE -> mem)
// master = CCE side, slave = memory model side.
interface bp_me_cce_mem_delay_model_if #(parameter int width_p = 573);
  logic [width_p-1:0] mem_cmd_i;
  logic               mem_cmd_v_i;
  logic               mem_cmd_yumi_o;
  logic [width_p-1:0] mem_resp_o;
  logic               mem_resp_v_o;
  logic               mem_resp_ready_i;

  modport master (
    output mem_cmd_i, mem_cmd_v_i, mem_resp_ready_i,
    input  mem_cmd_yumi_o, mem_resp_o, mem_resp_v_o
  );

  modport slave (
    input  mem_cmd_i, mem_cmd_v_i, mem_resp_ready_i,
    output mem_cmd_yumi_o, mem_resp_o, mem_resp_v_o
  );
endinterface

// File: rtl/bp_me_cce_mem_delay_model.sv
// Memory stub below the CCE: accepts one mem_cmd at a time, performs the RAM
// access at accept, and returns a mem_resp max(delay_p,1) cycles later.
// Backing store is an els_p-deep, block-wide flop array cleared on reset.
// Ports:
//   clk_i     : clock
//   reset_n_i : asynchronous active-low reset
//   mem       : slave modport of bp_me_cce_mem_delay_model_if
//               (mem_cmd_i/_v_i/_yumi_o, mem_resp_o/_v_o/_ready_i)
// Optional feature: define BP_ME_MEM_MODEL_STALL_EN to suppress accepts for
// 4 of every 16 cycles, driven by a free-running 4-bit counter.
module bp_me_cce_mem_delay_model #(
  parameter int paddr_width_p   = 40,
  parameter int block_width_p   = 512,
  parameter int payload_width_p = 16,
  parameter int els_p           = 64,
  parameter int delay_p         = 4
) (
  input logic clk_i,
  input logic reset_n_i,
  bp_me_cce_mem_delay_model_if.slave mem
);

  localparam int bytes_lp  = block_width_p / 8;
  localparam int lg_b_lp   = $clog2(bytes_lp);
  localparam int lg_els_lp = $clog2(els_p);
  localparam int cnt_w_lp  = (delay_p > 1) ? $clog2(delay_p) : 1;
  localparam logic [2:0]          lg_b_sz_lp = 3'(lg_b_lp);
  localparam logic [cnt_w_lp-1:0] cnt_init_lp = (delay_p > 1) ? cnt_w_lp'(delay_p - 1) : '0;

  typedef struct packed {
    logic [block_width_p-1:0]   data;
    logic [payload_width_p-1:0] payload;
    logic [2:0]                 size;
    logic [paddr_width_p-1:0]   addr;
    logic [1:0]                 msg_type; // [0]=write, [1]=uncached
  } mem_msg_s;

  typedef enum logic [1:0] {IDLE, DELAY, RESP} state_e;

  state_e                   state_r, state_n;
  logic [cnt_w_lp-1:0]      cnt_r, cnt_n;
  mem_msg_s                 cmd, resp_r;
  logic                     yumi, resp_v, stall;
  logic [lg_els_lp-1:0]     index;
  logic [lg_b_lp-1:0]       offset;
  logic [2:0]               eff_size;
  logic [bytes_lp-1:0]      be;
  logic [block_width_p-1:0] wdata;
  logic [block_width_p-1:0] ram [els_p];

  assign cmd      = mem.mem_cmd_i;
  assign index    = cmd.addr[lg_b_lp +: lg_els_lp];
  assign offset   = cmd.addr[lg_b_lp-1:0];
  // Oversized accesses collapse to a full-block access.
  assign eff_size = (cmd.size > lg_b_sz_lp) ? lg_b_sz_lp : cmd.size;

  // Byte i is enabled when it falls in the same 2^size-aligned chunk as the
  // offset; full-block writes enable every lane.
  always_comb begin
    be    = '0;
    wdata = '0;
    for (int i = 0; i < bytes_lp; i++) begin
      be[i] = ~cmd.msg_type[1] || ((lg_b_lp'(i) >> eff_size) == (offset >> eff_size));
      wdata[i*8 +: 8] = be[i] ? cmd.data[i*8 +: 8] : ram[index][i*8 +: 8];
    end
  end

`ifdef BP_ME_MEM_MODEL_STALL_EN
  logic [3:0] stall_cnt_r;
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) stall_cnt_r <= '0;
    else            stall_cnt_r <= stall_cnt_r + 4'd1;
  assign stall = &stall_cnt_r[3:2];
`else
  assign stall = 1'b0;
`endif

  always_comb begin
    state_n = state_r;
    cnt_n   = cnt_r;
    yumi    = 1'b0;
    resp_v  = 1'b0;
    case (state_r)
      IDLE: begin
        yumi = reset_n_i && mem.mem_cmd_v_i && !stall;
        if (yumi) begin
          if (delay_p > 1) begin
            state_n = DELAY;
            cnt_n   = cnt_init_lp;
          end else begin
            state_n = RESP;
          end
        end
      end
      DELAY: begin
        // Leaving on cnt==1 makes the DELAY stay delay_p-1 cycles long.
        cnt_n = cnt_r - 1'b1;
        if (cnt_r == cnt_w_lp'(1)) state_n = RESP;
      end
      RESP: begin
        resp_v = 1'b1;
        if (mem.mem_resp_ready_i) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) begin
      state_r <= IDLE;
      cnt_r   <= '0;
    end else begin
      state_r <= state_n;
      cnt_r   <= cnt_n;
    end

  // Header and read data are latched at accept and held through RESP.
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) begin
      resp_r <= '0;
    end else if (yumi) begin
      resp_r          <= cmd;
      resp_r.data     <= cmd.msg_type[0] ? '0 : ram[index];
    end

  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) begin
      for (int i = 0; i < els_p; i++) ram[i] <= '0;
    end else if (yumi && cmd.msg_type[0]) begin
      ram[index] <= wdata;
    end

  assign mem.mem_cmd_yumi_o = yumi;
  assign mem.mem_resp_v_o   = resp_v;
  assign mem.mem_resp_o     = resp_r;

  a_size_ok: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    yumi |-> (cmd.size <= 3'd6));
  a_v_known: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    !$isunknown(mem.mem_cmd_v_i));

endmodule
